// File: rtl/axi_lite_master.sv
// Single-outstanding AXI4-Lite master: turns level-sensitive write/read commands into one
// AXI4-Lite transaction each, with a per-state handshake timeout and a sticky error flag.
module axi_lite_master #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 1024
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    C_VALID,
  input  logic [ADDR_WIDTH-1:0]   C_ADRR,
  input  logic [DATA_WIDTH-1:0]   C_DATA,
  input  logic [DATA_WIDTH/8-1:0] C_STRB,
  input  logic                    C_VALID_R,
  input  logic [ADDR_WIDTH-1:0]   C_ADRR_R,
  output logic [DATA_WIDTH-1:0]   U_ADRR,
  output logic                    BUSY,
  output logic                    WR_DONE,
  output logic                    RD_DONE,
  output logic                    ERR,
  output logic [ADDR_WIDTH-1:0]   M_AXI_AWADDR,
  output logic                    M_AXI_AWVALID,
  input  logic                    M_AXI_AWREADY,
  output logic [DATA_WIDTH-1:0]   M_AXI_WDATA,
  output logic [DATA_WIDTH/8-1:0] M_AXI_WSTRB,
  output logic                    M_AXI_WVALID,
  input  logic                    M_AXI_WREADY,
  input  logic [1:0]              M_AXI_BRESP,
  input  logic                    M_AXI_BVALID,
  output logic                    M_AXI_BREADY,
  output logic [ADDR_WIDTH-1:0]   M_AXI_ARADDR,
  output logic                    M_AXI_ARVALID,
  input  logic                    M_AXI_ARREADY,
  input  logic [DATA_WIDTH-1:0]   M_AXI_RDATA,
  input  logic [1:0]              M_AXI_RRESP,
  input  logic                    M_AXI_RVALID,
  output logic                    M_AXI_RREADY
);

  localparam int SW    = DATA_WIDTH / 8;
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);
  localparam bit   TMO_EN  = (TIMEOUT != 0);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_WR_REQ  = 3'd1;
  localparam logic [2:0] ST_WR_RESP = 3'd2;
  localparam logic [2:0] ST_RD_REQ  = 3'd3;
  localparam logic [2:0] ST_RD_RESP = 3'd4;

  logic [2:0]            state_q,   state_d;
  logic [CNT_W-1:0]      tmo_cnt_q, tmo_cnt_d;
  logic                  awvalid_q, awvalid_d;
  logic                  wvalid_q,  wvalid_d;
  logic                  bready_q,  bready_d;
  logic                  arvalid_q, arvalid_d;
  logic                  rready_q,  rready_d;
  logic [ADDR_WIDTH-1:0] awaddr_q,  awaddr_d;
  logic [ADDR_WIDTH-1:0] araddr_q,  araddr_d;
  logic [DATA_WIDTH-1:0] wdata_q,   wdata_d;
  logic [SW-1:0]         wstrb_q,   wstrb_d;
  logic [DATA_WIDTH-1:0] u_adrr_q,  u_adrr_d;
  logic                  wr_done_q, wr_done_d;
  logic                  rd_done_q, rd_done_d;
  logic                  err_q,     err_d;
  logic                  tmo_hit;

  // A handshake in the same cycle as the limit wins over the timeout.
  assign tmo_hit = TMO_EN && (tmo_cnt_q == TMO_LAST);

  always_comb begin
    // NOTE: every next-state signal gets a hold/default value first so no path leaves it unassigned (no latches).
    state_d   = state_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    bready_d  = bready_q;
    arvalid_d = arvalid_q;
    rready_d  = rready_q;
    awaddr_d  = awaddr_q;
    araddr_d  = araddr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    u_adrr_d  = u_adrr_q;
    err_d     = err_q;
    wr_done_d = 1'b0;
    rd_done_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (C_VALID) begin
          awaddr_d  = C_ADRR;
          wdata_d   = C_DATA;
          wstrb_d   = C_STRB;
          awvalid_d = 1'b1;
          wvalid_d  = 1'b1;
          err_d     = 1'b0;
          state_d   = ST_WR_REQ;
        end else if (C_VALID_R) begin
          araddr_d  = C_ADRR_R;
          arvalid_d = 1'b1;
          err_d     = 1'b0;
          state_d   = ST_RD_REQ;
        end
      end
      ST_WR_REQ: begin
        // AW and W retire independently; B is only accepted once both are gone.
        awvalid_d = awvalid_q & ~M_AXI_AWREADY;
        wvalid_d  = wvalid_q & ~M_AXI_WREADY;
        if (!awvalid_d && !wvalid_d) begin
          bready_d = 1'b1;
          state_d  = ST_WR_RESP;
        end else if (tmo_hit) begin
          awvalid_d = 1'b0;
          wvalid_d  = 1'b0;
          wr_done_d = 1'b1;
          err_d     = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      ST_WR_RESP: begin
        if (M_AXI_BVALID) begin
          bready_d  = 1'b0;
          wr_done_d = 1'b1;
          err_d     = err_q | (M_AXI_BRESP != 2'b00);
          state_d   = ST_IDLE;
        end else if (tmo_hit) begin
          bready_d  = 1'b0;
          wr_done_d = 1'b1;
          err_d     = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      ST_RD_REQ: begin
        if (M_AXI_ARREADY) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = ST_RD_RESP;
        end else if (tmo_hit) begin
          arvalid_d = 1'b0;
          rd_done_d = 1'b1;
          err_d     = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      ST_RD_RESP: begin
        if (M_AXI_RVALID) begin
          u_adrr_d  = M_AXI_RDATA;
          rready_d  = 1'b0;
          rd_done_d = 1'b1;
          err_d     = err_q | (M_AXI_RRESP != 2'b00);
          state_d   = ST_IDLE;
        end else if (tmo_hit) begin
          rready_d  = 1'b0;
          rd_done_d = 1'b1;
          err_d     = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    tmo_cnt_d = tmo_cnt_q;
    if (state_d != state_q)     tmo_cnt_d = '0;
    else if (state_q != ST_IDLE) tmo_cnt_d = tmo_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      tmo_cnt_q <= '0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      awaddr_q  <= '0;
      araddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      u_adrr_q  <= '0;
      wr_done_q <= 1'b0;
      rd_done_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the pre-edge values.
      state_q   <= state_d;
      tmo_cnt_q <= tmo_cnt_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      bready_q  <= bready_d;
      arvalid_q <= arvalid_d;
      rready_q  <= rready_d;
      awaddr_q  <= awaddr_d;
      araddr_q  <= araddr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      u_adrr_q  <= u_adrr_d;
      wr_done_q <= wr_done_d;
      rd_done_q <= rd_done_d;
      err_q     <= err_d;
    end
  end

  assign BUSY          = (state_q != ST_IDLE);
  assign WR_DONE       = wr_done_q;
  assign RD_DONE       = rd_done_q;
  assign ERR           = err_q;
  assign U_ADRR        = u_adrr_q;
  assign M_AXI_AWADDR  = awaddr_q;
  assign M_AXI_AWVALID = awvalid_q;
  assign M_AXI_WDATA   = wdata_q;
  assign M_AXI_WSTRB   = wstrb_q;
  assign M_AXI_WVALID  = wvalid_q;
  assign M_AXI_BREADY  = bready_q;
  assign M_AXI_ARADDR  = araddr_q;
  assign M_AXI_ARVALID = arvalid_q;
  assign M_AXI_RREADY  = rready_q;

endmodule

// File: tb/tb_axi_lite_master.sv
// Bench for axi_lite_master: a delay-programmable AXI-Lite slave, a transaction-level timing
// model, a directed vector table, random transactions and a mid-write reset sequence.
module tb_axi_lite_master;

  localparam int T     = 16;
  localparam int LIMIT = 200;

  logic        clk = 1'b0;
  logic        reset;
  logic        c_valid, c_valid_r;
  logic [31:0] c_adrr, c_data, c_adrr_r;
  logic [3:0]  c_strb;
  logic [31:0] u_adrr;
  logic        busy, wr_done, rd_done, err;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [3:0]  wstrb;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [1:0]  bresp, rresp;

  axi_lite_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(T)) dut (
    .clk(clk), .reset(reset),
    .C_VALID(c_valid), .C_ADRR(c_adrr), .C_DATA(c_data), .C_STRB(c_strb),
    .C_VALID_R(c_valid_r), .C_ADRR_R(c_adrr_r),
    .U_ADRR(u_adrr), .BUSY(busy), .WR_DONE(wr_done), .RD_DONE(rd_done), .ERR(err),
    .M_AXI_AWADDR(awaddr), .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
    .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready),
    .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready),
    .M_AXI_ARADDR(araddr), .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
    .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready)
  );

  always #5 clk = ~clk;

  // d0/d1/d2: write = AWREADY, WREADY, BVALID delays; read = ARREADY, RVALID delays.
  typedef struct {
    logic        is_wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    int          d0;
    int          d1;
    int          d2;
    logic [1:0]  resp;
    logic        hold_rd;
    int          exp_done;
    logic        exp_err;
  } vec_t;

  typedef struct {
    int          done;
    int          hs0;
    int          hs1;
    int          hs2;
    int          rdy;
    logic        err;
    logic [31:0] u;
  } exp_t;

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [31:0] u_model  = '0;
  vec_t        vecs[15];

  task automatic check(input string nm, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", nm, act, act, exp, exp);
  endtask

  // Each wait phase lasts its slave delay; a phase that would need T or more cycles times out
  // after exactly T cycles. Cycle 0 is the cycle the command is presented in IDLE.
  function automatic exp_t model(input vec_t v, input logic [31:0] u_prev);
    exp_t e;
    int   p1;
    e.hs0 = -1; e.hs1 = -1; e.hs2 = -1; e.rdy = -1; e.u = u_prev;
    e.err = (v.resp != 2'b00);
    if (v.is_wr) begin
      p1 = (v.d0 > v.d1) ? v.d0 : v.d1;
      if (v.d0 < T) e.hs0 = 1 + v.d0;
      if (v.d1 < T) e.hs1 = 1 + v.d1;
      if (p1 >= T) begin
        e.done = 1 + T; e.err = 1'b1;
      end else begin
        e.rdy = 2 + p1;
        if (v.d2 >= T) begin
          e.done = e.rdy + T; e.err = 1'b1;
        end else begin
          e.hs2 = e.rdy + v.d2; e.done = e.hs2 + 1;
        end
      end
    end else begin
      if (v.d0 >= T) begin
        e.done = 1 + T; e.err = 1'b1;
      end else begin
        e.hs0 = 1 + v.d0;
        e.rdy = 2 + v.d0;
        if (v.d1 >= T) begin
          e.done = e.rdy + T; e.err = 1'b1;
        end else begin
          e.hs1 = e.rdy + v.d1; e.done = e.hs1 + 1; e.u = v.data;
        end
      end
    end
    return e;
  endfunction

  task automatic clear_slave();
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
    arready = 1'b0; rvalid = 1'b0; rresp = 2'b00; rdata = '0;
  endtask

  // Starts and ends on a falling edge; the ending edge is the DONE cycle (DUT back in IDLE).
  task automatic run_txn(input vec_t v, input string nm);
    exp_t        e;
    int          done_cyc = -1, seen0 = 0, seen1 = 0, rdy_first = -1, bad = 0, mx;
    int          hs_n0 = 0, hs_n1 = 0, hs_n2 = 0, hs_c0 = -1, hs_c1 = -1, hs_c2 = -1;
    logic        err1 = 1'b1, done_prev = 1'b1, err_at = 1'b0, busy_at = 1'b1;
    logic [31:0] cap_addr = '0, cap_data = '0, u_at = '0;
    logic [3:0]  cap_strb = '0;
    e = model(v, u_model);
    if (v.is_wr) begin
      c_valid = 1'b1; c_adrr = v.addr; c_data = v.data; c_strb = v.strb; c_valid_r = v.hold_rd;
    end else begin
      c_valid_r = 1'b1; c_adrr_r = v.addr;
    end
    @(posedge clk); @(negedge clk);
    c_valid = 1'b0;
    if (!v.hold_rd) c_valid_r = 1'b0;
    c_adrr = $urandom; c_data = $urandom; c_strb = 4'($urandom); c_adrr_r = $urandom;
    for (int cyc = 1; cyc <= LIMIT; cyc++) begin
      if (cyc == 1) begin err1 = err; done_prev = wr_done | rd_done; end
      if (v.is_wr ? rd_done : wr_done) bad++;
      if (v.is_wr ? wr_done : rd_done) begin
        done_cyc = cyc; err_at = err; busy_at = busy; u_at = u_adrr;
        break;
      end
      if ((v.is_wr ? bready : rready) && rdy_first < 0) rdy_first = cyc;
      if (v.is_wr ? (arvalid || rready) : (awvalid || wvalid || bready)) bad++;
      if (v.is_wr) begin
        awready = awvalid && (seen0 >= v.d0); if (awvalid) seen0++;
        wready  = wvalid && (seen1 >= v.d1);  if (wvalid) seen1++;
        mx      = (hs_c0 > hs_c1) ? hs_c0 : hs_c1;
        bvalid  = (hs_c0 >= 0) && (hs_c1 >= 0) && (hs_n2 == 0) && (cyc >= mx + 1 + v.d2);
        bresp   = bvalid ? v.resp : 2'($urandom);
        if (awvalid && awready) begin hs_n0++; hs_c0 = cyc; cap_addr = awaddr; end
        if (wvalid && wready) begin hs_n1++; hs_c1 = cyc; cap_data = wdata; cap_strb = wstrb; end
        if (bvalid && bready) begin hs_n2++; hs_c2 = cyc; end
      end else begin
        arready = arvalid && (seen0 >= v.d0); if (arvalid) seen0++;
        rvalid  = (hs_c0 >= 0) && (hs_n1 == 0) && (cyc >= hs_c0 + 1 + v.d1);
        rdata   = rvalid ? v.data : $urandom;
        rresp   = rvalid ? v.resp : 2'($urandom);
        if (arvalid && arready) begin hs_n0++; hs_c0 = cyc; cap_addr = araddr; end
        if (rvalid && rready) begin hs_n1++; hs_c1 = cyc; end
      end
      @(posedge clk); @(negedge clk);
    end
    clear_slave();
    check({nm, ".done_cycle"}, done_cyc, e.done);
    check({nm, ".hs0_count"}, hs_n0, (e.hs0 >= 0) ? 1 : 0);
    check({nm, ".hs0_cycle"}, hs_c0, e.hs0);
    check({nm, ".hs1_count"}, hs_n1, (e.hs1 >= 0) ? 1 : 0);
    check({nm, ".hs1_cycle"}, hs_c1, e.hs1);
    if (v.is_wr) check({nm, ".b_cycle"}, hs_c2, e.hs2);
    check({nm, ".resp_ready_first"}, rdy_first, e.rdy);
    if (hs_n0 > 0) check({nm, ".addr"}, cap_addr, v.addr);
    if (v.is_wr && hs_n1 > 0) begin
      check({nm, ".wdata"}, cap_data, v.data);
      check({nm, ".wstrb"}, cap_strb, v.strb);
    end
    check({nm, ".err_cleared"}, err1, 0);
    check({nm, ".prev_done_1cyc"}, done_prev, 0);
    check({nm, ".err"}, err_at, e.err);
    check({nm, ".busy_at_done"}, busy_at, 0);
    check({nm, ".u_adrr"}, u_at, e.u);
    check({nm, ".other_channel"}, bad, 0);
    if (v.exp_done >= 0) begin
      check({nm, ".tbl_done"}, done_cyc, v.exp_done);
      check({nm, ".tbl_err"}, err_at, v.exp_err);
    end
    u_model = e.u;
  endtask

  task automatic check_reset_outputs(input string nm);
    check({nm, ".u_adrr"}, u_adrr, 0);
    check({nm, ".flags"}, {busy, wr_done, rd_done, err}, 0);
    check({nm, ".handshake"}, {awvalid, wvalid, bready, arvalid, rready}, 0);
    check({nm, ".awaddr_araddr"}, {awaddr, araddr}, 0);
    check({nm, ".wdata_wstrb"}, {wdata, wstrb}, 0);
  endtask

  function automatic int pick_delay();
    return ($urandom_range(0, 9) == 0) ? T + int'($urandom_range(0, 4)) : int'($urandom_range(0, 5));
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    logic dones;
    // is_wr addr data strb d0 d1 d2 resp hold_rd exp_done exp_err
    vecs[0]  = '{1'b1, 32'h0000_0000, 32'h0000_5A5A, 4'hF, 0,    0,  0,  2'b00, 1'b0, 3,  1'b0};
    vecs[1]  = '{1'b0, 32'h0000_0010, 32'h0000_1234, 4'h0, 3,    0,  0,  2'b00, 1'b0, 6,  1'b0};
    vecs[2]  = '{1'b1, 32'h0000_0100, 32'h1111_2222, 4'hF, 5,    0,  0,  2'b00, 1'b0, 8,  1'b0};
    vecs[3]  = '{1'b1, 32'h0000_0104, 32'h3333_4444, 4'hC, 0,    5,  0,  2'b00, 1'b0, 8,  1'b0};
    vecs[4]  = '{1'b1, 32'h0000_0020, 32'h0000_CAFE, 4'hF, 0,    0,  0,  2'b00, 1'b1, 3,  1'b0};
    vecs[5]  = '{1'b0, 32'h0000_0024, 32'h0BAD_F00D, 4'h0, 0,    0,  0,  2'b00, 1'b0, 3,  1'b0};
    vecs[6]  = '{1'b1, 32'h0000_0030, 32'h0000_00AA, 4'h1, 0,    0,  0,  2'b10, 1'b0, 3,  1'b1};
    vecs[7]  = '{1'b0, 32'h0000_0034, 32'hDEAD_BEEF, 4'h0, 0,    1,  0,  2'b10, 1'b0, 4,  1'b1};
    vecs[8]  = '{1'b1, 32'h0000_0040, 32'h0000_0001, 4'h3, 1,    2,  1,  2'b00, 1'b0, 6,  1'b0};
    vecs[9]  = '{1'b0, 32'h0000_0050, 32'h5555_5555, 4'h0, 1000, 0,  0,  2'b00, 1'b0, 17, 1'b1};
    vecs[10] = '{1'b0, 32'h0000_0054, 32'h6666_6666, 4'h0, 0,    30, 0,  2'b00, 1'b0, 18, 1'b1};
    vecs[11] = '{1'b1, 32'h0000_0058, 32'h7777_7777, 4'hF, 0,    0,  40, 2'b00, 1'b0, 18, 1'b1};
    vecs[12] = '{1'b1, 32'h0000_005C, 32'h8888_8888, 4'hF, 100,  2,  0,  2'b00, 1'b0, 17, 1'b1};
    vecs[13] = '{1'b0, 32'h0000_0060, 32'h0000_1357, 4'h0, 2,    2,  0,  2'b00, 1'b0, 7,  1'b0};
    vecs[14] = '{1'b0, 32'h0000_0064, 32'h0000_2468, 4'h0, 15,   0,  0,  2'b00, 1'b0, 18, 1'b0};

    reset = 1'b1;
    c_valid = 1'b0; c_valid_r = 1'b0; c_adrr = '0; c_data = '0; c_strb = '0; c_adrr_r = '0;
    clear_slave();
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 15; i++) run_txn(vecs[i], $sformatf("vec%0d", i));

    for (int i = 0; i < 40; i++) begin
      v.is_wr    = 1'($urandom_range(0, 1));
      v.addr     = $urandom;
      v.data     = $urandom;
      v.strb     = 4'($urandom);
      v.d0       = pick_delay();
      v.d1       = pick_delay();
      v.d2       = pick_delay();
      v.resp     = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      v.hold_rd  = 1'b0;
      v.exp_done = -1;
      v.exp_err  = 1'b0;
      run_txn(v, $sformatf("rnd%0d", i));
    end

    // Reset asserted between clock edges while a write is stalled on AW/W.
    c_valid = 1'b1; c_adrr = 32'hA5A5_0000; c_data = 32'h1234_5678; c_strb = 4'hF;
    @(posedge clk); @(negedge clk);
    c_valid = 1'b0;
    check("midrst.busy_before", busy, 1);
    check("midrst.awvalid_before", awvalid, 1);
    #2 reset = 1'b1;
    #1 check_reset_outputs("midrst");
    @(negedge clk);
    reset = 1'b0;
    dones = 1'b0;
    repeat (4) begin
      @(negedge clk);
      dones = dones | wr_done | rd_done | busy;
    end
    check("midrst.no_done_after", dones, 0);
    u_model = '0;
    run_txn(vecs[0], "post_reset");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
